// File: rtl/comefa_pkg.sv
// Shared types and constants for the dual-port RAM burst reader.
// Combinational only: no state or timing of its own.
// Backpressure is not applicable; this file only holds declarations.
package comefa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Output skid buffer depth; the read credit rule is sized against this.
    localparam int SKID_DEPTH = 2;

    // Width of a count that can hold 0..SKID_DEPTH.
    localparam int SKID_CW = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/dpram_skid_fifo.sv
// Small skid FIFO holding {last, data} words returned by the RAM.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: the head holds until popped; a push into a full FIFO is dropped.
module dpram_skid_fifo
    import comefa_pkg::*;
#(
    parameter int W = 33
)
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               push,
    input  logic [W-1:0]       din,
    input  logic               pop,
    output logic [W-1:0]       dout,
    output logic [SKID_CW-1:0] count
);

    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    logic [W-1:0]  mem [SKID_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop frees a slot in the same cycle, so push into a full FIFO is legal then.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != SKID_CW'(SKID_DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + SKID_CW'(1);
                2'b01:   count <= count - SKID_CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dpram_burst_reader.sv
// Burst read master: turns (addr, len) commands into sequential RAM reads streamed out.
// Latency: first word valid 2 cycles after the command handshake, then 1 word/cycle.
// Backpressure: out_ready stalls issue through a 2-slot credit so no returned word is lost.
module dpram_burst_reader
    import comefa_pkg::*;
#(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 32,
    parameter int NUM_WORDS = 1024
)
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH:0]   cmd_len,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_wren,
    input  logic [DWIDTH-1:0] ram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // Longer requests are clipped to the RAM depth.
    localparam logic [AWIDTH:0] MAX_LEN = (AWIDTH + 1)'(NUM_WORDS);

    state_t              state;
    state_t              state_nxt;
    logic [AWIDTH-1:0]   next_addr;
    logic [AWIDTH:0]     remaining;
    logic [AWIDTH:0]     len_clamped;
    logic                rd_pending;
    logic                pend_last;
    logic                issue;
    logic                cmd_take;
    logic                drain_done;
    logic                pop;
    logic [SKID_CW-1:0]  fifo_count;
    logic [DWIDTH:0]     fifo_head;
    logic [SKID_CW:0]    occ;
    logic [SKID_CW:0]    occ_limit;

    assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

    // Words buffered plus the one in flight must leave room for the in-flight capture;
    // a pop this cycle returns one credit early so the stream sustains 1 word/cycle.
    assign occ       = {1'b0, fifo_count} + {{SKID_CW{1'b0}}, rd_pending};
    assign occ_limit = (SKID_CW + 1)'(SKID_DEPTH) + {{SKID_CW{1'b0}}, pop};

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_head[DWIDTH-1:0] : '0;
    assign out_last  = out_valid && fifo_head[DWIDTH];
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ram_wren  = 1'b0;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, command acceptance, read issue and drain completion.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        cmd_take   = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_take = 1'b1;
                    if (len_clamped != '0) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                issue = (remaining != '0) && (occ < occ_limit);
                if (issue && (remaining == (AWIDTH + 1)'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Nothing left in flight and the last buffered word leaves this cycle.
                drain_done = !rd_pending &&
                             ((fifo_count == '0) ||
                              ((fifo_count == SKID_CW'(1)) && pop));
                if (drain_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/length bookkeeping, in-flight tag and the completion pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_addr   <= '0;
            next_addr  <= '0;
            remaining  <= '0;
            rd_pending <= 1'b0;
            pend_last  <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                ram_addr  <= next_addr;
                pend_last <= (remaining == (AWIDTH + 1)'(1));
                next_addr <= next_addr + AWIDTH'(1);
                remaining <= remaining - (AWIDTH + 1)'(1);
            end else if (cmd_take) begin
                next_addr <= cmd_addr;
                remaining <= len_clamped;
            end
            done <= (cmd_take && (len_clamped == '0)) || drain_done;
        end
    end

    // The RAM re-reads every cycle, so the word is captured on the edge after issue.
    dpram_skid_fifo #(
        .W (DWIDTH + 1)
    ) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .push   (rd_pending),
        .din    ({pend_last, ram_rdata}),
        .pop    (pop),
        .dout   (fifo_head),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Scoreboard bench for dpram_burst_reader with a behavioural RAM and reference model.
// Expected words are computed per command from the RAM contents; a monitor checks them.
// Backpressure patterns: always ready, fixed toggle pattern, and random.
module tb_dpram_burst_reader;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NW = 1024;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [DW-1:0] ram_rdata;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:NW-1];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int hs_cyc   = 0;
    int done_cnt = 0;
    int done_exp_cyc = -1;
    int ready_mode = 0;
    int tog_idx  = 0;
    logic [5:0] tog_pat = 6'b101001;   // 1,0,0,1,0,1 read from bit 0 upward
    bit busy_seen = 0;

    logic [DW:0]   exp_q [$];
    int            accept_cyc [$];
    int            addr_chg_cyc [$];
    logic [AW-1:0] addr_seen [$];

    logic          prev_stall = 1'b0;
    logic [DW:0]   prev_word = '0;
    logic [AW-1:0] prev_addr = '0;

    dpram_burst_reader #(
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .NUM_WORDS (NW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_addr  (ram_addr),
        .ram_wren  (ram_wren),
        .ram_rdata (ram_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // RAM port: the registered ram_addr selects the word returned in the following cycle.
    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Consumer ready pattern, updated just after each rising edge.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 9) < 7);
            default: begin
                out_ready = tog_pat[tog_idx];
                tog_idx   = (tog_idx + 1) % 6;
            end
        endcase
    end

    // Monitor: samples on the falling edge, pops the scoreboard on every handshake.
    always @(negedge clk) begin
        logic [DW:0] w;
        if (resetn === 1'b1) begin
            if (ram_wren !== 1'b0) fail("ram_wren_nonzero");
            if (busy) busy_seen = 1;
            if (prev_stall) check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
            if (ram_addr !== prev_addr) begin
                addr_seen.push_back(ram_addr);
                addr_chg_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                check("done_time", cyc, done_exp_cyc);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_word");
                end else begin
                    w = exp_q.pop_front();
                    check("word", {out_last, out_data}, w);
                    accept_cyc.push_back(cyc);
                    if (w[DW]) done_exp_cyc = cyc + 1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end else begin
            prev_stall = 1'b0;
        end
        prev_addr = ram_addr;
    end

    task automatic clear_logs();
        accept_cyc.delete();
        addr_chg_cyc.delete();
        addr_seen.delete();
        busy_seen = 0;
    endtask

    // Issue one command; expected words come straight from the RAM image.
    task automatic send_cmd(input logic [AW-1:0] a, input logic [AW:0] len);
        int t = 0;
        while (!cmd_ready && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        if (!cmd_ready) fail("cmd_ready_timeout");
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back({(i == int'(len) - 1), mem[(int'(a) + i) % NW]});
        end
        if (len == 0) done_exp_cyc = cyc + 1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = len;
        hs_cyc    = cyc + 1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start_done);
        int t = 0;
        while (done_cnt == start_done && t < 4000) begin
            @(posedge clk); #1; t++;
        end
        check("done_count", done_cnt, start_done + 1);
        check("scoreboard_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_addrs(input int start, input int len, input bit timing);
        check("addr_count", addr_seen.size(), len);
        for (int i = 0; i < len && i < addr_seen.size(); i++) begin
            check("addr_seq", addr_seen[i], (start + i) % NW);
            if (timing) check("addr_cycle", addr_chg_cyc[i], hs_cyc + 1 + i);
        end
    endtask

    initial begin
        int d0;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        for (int i = 0; i < NW; i++) mem[i] = DW'(i * 3);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wren", ram_wren, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_out_valid", out_valid, 0);
        check("idle_done_cnt", done_cnt, 0);

        // Directed burst at full throughput.
        ready_mode = 0;
        clear_logs();
        d0 = done_cnt;
        send_cmd(10'd5, 11'd4);
        wait_done(d0);
        check_addrs(5, 4, 1);
        check("accept_count", accept_cyc.size(), 4);
        for (int i = 0; i < accept_cyc.size(); i++) begin
            check("accept_cycle", accept_cyc[i], hs_cyc + 2 + i);
        end

        // Address wrap.
        clear_logs();
        d0 = done_cnt;
        send_cmd(10'd1022, 11'd4);
        wait_done(d0);
        check_addrs(1022, 4, 1);

        // Toggled backpressure.
        ready_mode = 2;
        tog_idx    = 0;
        clear_logs();
        d0 = done_cnt;
        send_cmd(10'd300, 11'd6);
        wait_done(d0);
        check_addrs(300, 6, 0);
        check("toggle_accepts", accept_cyc.size(), 6);

        // Zero-length command.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        d0 = done_cnt;
        send_cmd(10'd7, 11'd0);
        wait_done(d0);
        repeat (3) @(posedge clk);
        #1;
        check("len0_busy", busy_seen, 0);
        check("len0_addr_changes", addr_seen.size(), 0);
        check("len0_accepts", accept_cyc.size(), 0);

        // Reset in the middle of an 8-word burst.
        clear_logs();
        d0 = done_cnt;
        send_cmd(10'd100, 11'd8);
        for (int t = 0; t < 100 && accept_cyc.size() < 2; t++) begin
            @(posedge clk); #1;
        end
        check("mid_accepts", accept_cyc.size(), 2);
        resetn = 1'b0;
        exp_q.delete();
        done_exp_cyc = -1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt, d0);
        check("mid_rst_idle_valid", out_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        d0 = done_cnt;
        send_cmd(10'd200, 11'd5);
        wait_done(d0);

        // Randomised bursts against random RAM contents.
        for (int i = 0; i < NW; i++) mem[i] = $urandom;
        for (int n = 0; n < 14; n++) begin
            logic [AW-1:0] a;
            logic [AW:0]   l;
            a = AW'($urandom_range(0, NW - 1));
            l = ($urandom_range(0, 6) == 0) ? '0 : (AW + 1)'($urandom_range(1, 40));
            ready_mode = (n % 4 == 0) ? 0 : 1;
            d0 = done_cnt;
            send_cmd(a, l);
            wait_done(d0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
